// File: rtl/data_mem_responder.sv
// Wait-state word memory for the CPU MEM stage. Each accepted load or store completes
// with a one-cycle ready_o pulse exactly LATENCY cycles after acceptance.
module data_mem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        busy_o
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];
    logic          addr_bad;
    logic [IW-1:0] idx;
    logic          do_access;

    // Full 30-bit word index compare, so addresses above DEPTH never alias into the array.
    assign addr_bad  = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    assign idx       = addr_q[IW+1:2];
    assign do_access = (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_i) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_o <= '0;
        end else begin
            if (state == IDLE && req_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (do_access) begin
                err_q <= addr_bad;
                if (addr_bad)   rdata_o <= '0;
                else if (!we_q) rdata_o <= mem[idx];
            end
        end
    end

    // Reset clears the array, which also drops a store that was still in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_access && !addr_bad && we_q) begin
            mem[idx] <= wdata_q;
        end
    end

    assign ready_o = (state == RESP);
    assign err_o   = ready_o & err_q;
    assign busy_o  = (state != IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + randomized bench for data_mem_responder; LATENCY=3 and LATENCY=1 instances
// are checked against a word-array reference model.
module tb_data_mem_responder;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req3 = 1'b0, req1 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata3, rdata1;
    logic        ready3, ready1, err3, err1, busy3, busy1;

    int checks = 0;
    int failures = 0;

    logic [31:0] m3 [DEPTH];
    logic [31:0] m1 [DEPTH];
    logic [31:0] last3, last1;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req3), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata3), .ready_o(ready3), .err_o(err3), .busy_o(busy3));

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata1), .ready_o(ready1), .err_o(err1), .busy_o(busy1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a / 4 >= DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m3[i] = '0;
            m1[i] = '0;
        end
        last3 = '0;
        last1 = '0;
    endtask

    // Issue one access to the selected instance and check its whole completion.
    task automatic access(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d);
        int lat, n;
        bit e;
        logic [31:0] exp_rd;
        lat = sel ? 1 : 3;
        e = bad_addr(a);
        @(negedge clk);
        we = w; addr = a; wdata = d;
        if (sel) req1 = 1'b1; else req3 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0; req3 = 1'b0;
        we = ~w; addr = $urandom; wdata = $urandom;   // post-acceptance changes must not matter
        chk("busy_after_accept", 32'(sel ? busy1 : busy3), 32'd1);
        n = 0;
        while (!(sel ? ready1 : ready3) && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (!(sel ? ready1 : ready3)) chk("busy_while_waiting", 32'(sel ? busy1 : busy3), 32'd1);
        end
        chk("latency", n, lat);
        chk("busy_in_resp", 32'(sel ? busy1 : busy3), 32'd1);
        chk("err", 32'(sel ? err1 : err3), 32'(e));
        if (!w) begin
            exp_rd = e ? 32'd0 : (sel ? m1[a / 4] : m3[a / 4]);
            chk("load_rdata", sel ? rdata1 : rdata3, exp_rd);
            if (sel) last1 = exp_rd; else last3 = exp_rd;
        end else if (!e) begin
            chk("store_rdata_hold", sel ? rdata1 : rdata3, sel ? last1 : last3);
            if (sel) m1[a / 4] = d; else m3[a / 4] = d;
        end else begin
            if (sel) last1 = '0; else last3 = '0;
        end
        @(posedge clk); #1;
        chk("ready_one_cycle", 32'(sel ? ready1 : ready3), 32'd0);
        chk("idle_after_resp", 32'(sel ? busy1 : busy3), 32'd0);
        chk("err_low_outside_resp", 32'(sel ? err1 : err3), 32'd0);
    endtask

    initial begin
        int acc_cnt, last_acc, cyc;
        bit prev_busy, pend;
        logic        dw, pw;
        logic [31:0] da, dd, pa, pd;
        logic [31:0] ra;
        model_reset();
        #12;
        chk("reset_ready3", 32'(ready3), 32'd0);
        chk("reset_busy3", 32'(busy3), 32'd0);
        chk("reset_err3", 32'(err3), 32'd0);
        chk("reset_rdata3", rdata3, 32'd0);
        chk("reset_rdata1", rdata1, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Basic store/load, then error cases and a re-read.
        access(0, 1, 32'h10, 32'hDEADBEEF);
        access(0, 0, 32'h10, 32'h0);
        access(0, 0, 32'h12, 32'h0);
        access(0, 0, 32'h200, 32'h0);
        access(0, 0, 32'h8000_0010, 32'h0);
        access(0, 1, 32'h204, 32'h5555_5555);
        access(0, 0, 32'h10, 32'h0);
        access(0, 1, 32'h1FC, 32'hA5A5A5A5);
        access(0, 0, 32'h1FC, 32'h0);

        // Continuous request with inputs changing every cycle.
        acc_cnt = 0; last_acc = 0; prev_busy = 1'b0; pend = 1'b0;
        pw = 1'b0; pa = '0; pd = '0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc < 30) begin
                dw = 1'($urandom_range(0, 1));
                da = 32'($urandom_range(0, 7)) * 4;
                if ($urandom_range(0, 5) == 0) da = da + 2;
                dd = $urandom;
                we = dw; addr = da; wdata = dd; req3 = 1'b1;
            end else begin
                req3 = 1'b0;
            end
            @(posedge clk); #1;
            if (busy3 && !prev_busy) begin
                if (acc_cnt > 0) chk("accept_spacing", cyc - last_acc, 5);
                acc_cnt++;
                last_acc = cyc;
                pend = 1'b1;
                pw = dw; pa = da; pd = dd;
            end
            if (ready3) begin
                chk("held_req_pending", 32'(pend), 32'd1);
                chk("held_req_latency", cyc - last_acc, 3);
                chk("held_req_err", 32'(err3), 32'(bad_addr(pa)));
                if (!pw) begin
                    chk("held_req_rdata", rdata3, bad_addr(pa) ? 32'd0 : m3[pa / 4]);
                    last3 = bad_addr(pa) ? 32'd0 : m3[pa / 4];
                end else if (!bad_addr(pa)) begin
                    m3[pa / 4] = pd;
                end else begin
                    last3 = '0;
                end
                pend = 1'b0;
            end
            prev_busy = busy3;
        end
        chk("held_req_accepts", acc_cnt, 6);
        chk("held_req_drained", 32'(busy3), 32'd0);

        // Reset one cycle after accepting a store.
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy3), 32'd0);
        chk("rst_ready", 32'(ready3), 32'd0);
        chk("rst_err", 32'(err3), 32'd0);
        chk("rst_rdata", rdata3, 32'd0);
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_no_ready", 32'(ready3), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        access(0, 0, 32'h20, 32'h0);
        access(0, 0, 32'h10, 32'h0);

        // LATENCY=1 instance.
        access(1, 1, 32'h0, 32'hCAFEF00D);
        access(1, 0, 32'h0, 32'h0);
        access(1, 1, 32'h1FC, 32'hA5A5A5A5);
        access(1, 0, 32'h1FC, 32'h0);
        access(1, 0, 32'h3, 32'h0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 60; i++) begin
            ra = 32'($urandom_range(0, 135)) * 4;
            if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) ra = $urandom;
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
